buzz_drv: RTL and testbench
===========================

# buzz_drv

Piezo buzzer driver downstream of the command FSM. It turns the FSM's `in_transit` status and the obstacle/`OK2Move` input into a differential square-wave tone on `buzz`/`buzz_n`. The tone is gated by an on/off cadence while the robot is blocked in transit. An optional short chirp marks station arrival.

## Interface
Parameters:
- `TONE_DIV`, 12500: tone half-period in clocks (2 kHz at 50 MHz); legal ≥2
- `ON_CYC`, 12500000: alarm cadence on-time in clocks; legal ≥2
- `OFF_CYC`, 12500000: alarm cadence off-time in clocks; legal ≥2
- `CHIRP_CYC`, 5000000: arrival chirp length in clocks; legal ≥2

Ports:
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  reset, asynchronous, active-high
- `in_transit`  in  1  from command FSM, high while robot is commanded to move
- `OK2Move`  in  1  high when path is clear
- `arrive`  in  1  one-cycle pulse from command FSM on station-ID match
- `buzz`  out  1  piezo drive, positive leg
- `buzz_n`  out  1  piezo drive, negative leg
- `busy`  out  1  high in any sounding or cadence state

## Operation
- `alarm = in_transit & ~OK2Move`, sampled each rising edge.
- States:
  - `IDLE`: silent, with `buzz` = `buzz_n` = 0 so no DC sits across the piezo.
  - `ALM_ON`: tone sounding during the alarm cadence.
  - `ALM_OFF`: silent gap in the alarm cadence.
  - `CHIRP`: tone sounding for the arrival chirp.
- Transitions:
  - `IDLE`: `alarm` → `ALM_ON`. Otherwise `arrive` → `CHIRP`. `alarm` wins if both are high on the same edge.
  - `ALM_ON`:
    - `~alarm` → `IDLE`. This takes priority over the cadence terminal count.
    - Cadence count reaching `ON_CYC-1` → `ALM_OFF`.
  - `ALM_OFF`:
    - `~alarm` → `IDLE`.
    - Count reaching `OFF_CYC-1` → `ALM_ON`.
  - `CHIRP`:
    - `alarm` → `ALM_ON`, aborting the chirp.
    - Count reaching `CHIRP_CYC-1` → `IDLE`.
    - `arrive` during the chirp restarts the count at 0 without a phase reset.
  - `arrive` is ignored in `ALM_ON` and `ALM_OFF`.
- Cadence/chirp counter:
  - Shared; width `$clog2` of the largest of `ON_CYC`, `OFF_CYC`, `CHIRP_CYC`.
  - Cleared on every state change; increments by 1 otherwise, with no wrap inside a state.
- Tone counter:
  - Width `$clog2(TONE_DIV)`; counts 0..`TONE_DIV-1`, and at terminal count wraps to 0 and toggles `phase`.
  - On entry to a sounding state, the tone counter clears and `phase` is set to 1.
- Outputs are flops:
  - Sounding: `buzz` = `phase`, `buzz_n` = `~phase`, never both 1.
  - Silent: both 0.
  - `busy` = 1 in `ALM_ON`, `ALM_OFF` and `CHIRP`.

## Timing
- Reset values: state `IDLE`, both counters 0, `phase` 0, `buzz` 0, `buzz_n` 0, `busy` 0.
- Reset asserted mid-tone forces all outputs low immediately (asynchronous), with no glitch to the complementary value.
- Latency: `alarm` or `arrive` sampled at edge E → `buzz`=1, `buzz_n`=0, `busy`=1 valid after E.
- The first tone half-period lasts `TONE_DIV` cycles; thereafter the outputs toggle every `TONE_DIV` cycles.
- `ALM_ON` lasts exactly `ON_CYC` cycles and `ALM_OFF` exactly `OFF_CYC` cycles while `alarm` holds.
- `alarm` dropping at edge E → `IDLE` and both outputs 0 after E, mid-half-period or not.
- A completed chirp drives the tone for exactly `CHIRP_CYC` cycles, then both outputs are 0.
- Inputs come from the same clock domain; no synchronizers.

## Configuration
- `BUZZ_CHIRP_EN`:
  - Defined: the `CHIRP` state and `arrive` handling are present as described.
  - Undefined: `CHIRP` is absent and `arrive` is unused, left unconnected internally without lint waivers beyond the unused port. The counter width ignores `CHIRP_CYC`. The block sounds only the alarm cadence.

## Test plan
All scenarios use `TONE_DIV`=4, `ON_CYC`=20, `OFF_CYC`=12, `CHIRP_CYC`=10.
- Reset release with `in_transit`=0 → `buzz`=`buzz_n`=`busy`=0 held for 100 cycles; `arrive` absent.
- `in_transit`=1, `OK2Move`=0 held for 100 cycles → `buzz` pattern 1111 0000 ×2 plus 1111 (20 cycles) then 0 for 12 cycles, repeating. `buzz_n` is complementary while sounding and 0 during the gap.
- Alarm active, `OK2Move`→1 at cycle 6 of `ALM_ON` → both outputs 0 and `busy`=0 on the next edge; reassert → tone restarts with `phase`=1.
- `arrive` pulse in `IDLE` (`BUZZ_CHIRP_EN` defined) → 10 cycles of tone (1111 0000 11), then `IDLE`. A second `arrive` at chirp cycle 5 extends total sounding to 15 cycles.
- `arrive` and `alarm` on the same edge → `ALM_ON` entered, and no chirp follows when the alarm clears. `alarm` during a chirp → chirp aborted, cadence starts at count 0.
- Build without `BUZZ_CHIRP_EN` → `arrive` pulses produce no output; alarm cadence is identical to scenario 2.

Source files
------------

// File: rtl/buzz_drv.sv
// buzz_drv: differential piezo driver for the obstacle alarm cadence and the
// optional station-arrival chirp.
//
// Build option: define BUZZ_CHIRP_EN to include the CHIRP state and the
// handling of the arrive pulse. Without it the block sounds only the alarm
// cadence and arrive is ignored.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | silent, buzz = buzz_n = 0 (no DC across the piezo)
// ALM_ON  | alarm cadence, tone sounding for ON_CYC cycles
// ALM_OFF | alarm cadence, silent gap for OFF_CYC cycles
// CHIRP   | arrival chirp, tone sounding for CHIRP_CYC cycles
module buzz_drv #(
    parameter int TONE_DIV  = 12500,
    parameter int ON_CYC    = 12500000,
    parameter int OFF_CYC   = 12500000,
    parameter int CHIRP_CYC = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic in_transit,
    input  logic OK2Move,
    input  logic arrive,
    output logic buzz,
    output logic buzz_n,
    output logic busy
);

    // Shared cadence/chirp counter is sized for the longest interval it times.
    localparam int MAX_AO = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
`ifdef BUZZ_CHIRP_EN
    localparam int MAX_CYC = (CHIRP_CYC > MAX_AO) ? CHIRP_CYC : MAX_AO;
`else
    localparam int MAX_CYC = MAX_AO;
`endif
    localparam int CW = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam int TW = (TONE_DIV > 2) ? $clog2(TONE_DIV) : 1;

    localparam logic [CW-1:0] ON_TC   = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] OFF_TC  = CW'(OFF_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [TW-1:0] TONE_TC = TW'(TONE_DIV - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ALM_ON  = 2'd1;
    localparam logic [1:0] ALM_OFF = 2'd2;
`ifdef BUZZ_CHIRP_EN
    localparam logic [1:0]    CHIRP    = 2'd3;
    localparam logic [CW-1:0] CHIRP_TC = CW'(CHIRP_CYC - 1);
`else
    localparam int unused_chirp_cyc = CHIRP_CYC;
    logic unused_arrive;
    assign unused_arrive = arrive;
`endif

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          phase, phase_nxt;
    logic          alarm;
    logic          restart;
    logic          sounding_nxt;
    logic          enter_sound;

    assign alarm = in_transit & ~OK2Move;

    // Next-state decode; alarm always outranks the chirp and the timers.
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (alarm) begin
                    state_nxt = ALM_ON;
                end
`ifdef BUZZ_CHIRP_EN
                else if (arrive) begin
                    state_nxt = CHIRP;
                end
`endif
            end
            ALM_ON: begin
                if (!alarm) begin
                    state_nxt = IDLE;
                end else if (cnt == ON_TC) begin
                    state_nxt = ALM_OFF;
                end
            end
            ALM_OFF: begin
                if (!alarm) begin
                    state_nxt = IDLE;
                end else if (cnt == OFF_TC) begin
                    state_nxt = ALM_ON;
                end
            end
`ifdef BUZZ_CHIRP_EN
            CHIRP: begin
                if (alarm) begin
                    state_nxt = ALM_ON;
                end else if (arrive) begin
                    // A fresh arrival extends the chirp; tone phase runs on.
                    restart = 1'b1;
                end else if (cnt == CHIRP_TC) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Interval counter: cleared on any state change or chirp restart, saturates otherwise.
    always_comb begin
        cnt_nxt = cnt;
        if ((state_nxt != state) || restart || (state == IDLE)) begin
            cnt_nxt = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // Tone generator: starts each sounding interval with a full high half-period.
    always_comb begin
`ifdef BUZZ_CHIRP_EN
        sounding_nxt = (state_nxt == ALM_ON) || (state_nxt == CHIRP);
`else
        sounding_nxt = (state_nxt == ALM_ON);
`endif
        enter_sound = sounding_nxt && (state_nxt != state);
        tcnt_nxt    = tcnt;
        phase_nxt   = phase;
        if (!sounding_nxt) begin
            tcnt_nxt  = '0;
            phase_nxt = 1'b0;
        end else if (enter_sound) begin
            tcnt_nxt  = '0;
            phase_nxt = 1'b1;
        end else if (tcnt == TONE_TC) begin
            tcnt_nxt  = '0;
            phase_nxt = ~phase;
        end else begin
            tcnt_nxt = tcnt + 1'b1;
        end
    end

    // State, counters and registered drive; outputs follow the next state so
    // a sampled request shows on the pins right after that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            tcnt   <= '0;
            phase  <= 1'b0;
            buzz   <= 1'b0;
            buzz_n <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            tcnt   <= tcnt_nxt;
            phase  <= phase_nxt;
            buzz   <= sounding_nxt & phase_nxt;
            buzz_n <= sounding_nxt & ~phase_nxt;
            busy   <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_buzz_drv.sv
// tb_buzz_drv: directed test of buzz_drv with TONE_DIV=4, ON_CYC=20,
// OFF_CYC=12, CHIRP_CYC=10. Chirp scenarios follow the BUZZ_CHIRP_EN build.
module tb_buzz_drv;

    logic clk = 1'b0;
    logic rst;
    logic in_transit;
    logic OK2Move;
    logic arrive;
    logic buzz;
    logic buzz_n;
    logic busy;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] SILENT = 3'b000;

    buzz_drv #(
        .TONE_DIV (4),
        .ON_CYC   (20),
        .OFF_CYC  (12),
        .CHIRP_CYC(10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_transit(in_transit),
        .OK2Move   (OK2Move),
        .arrive    (arrive),
        .buzz      (buzz),
        .buzz_n    (buzz_n),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Expected {buzz,buzz_n,busy} for cycle k of a cadence (32-cycle period).
    function automatic logic [2:0] cad_exp(input int k);
        int m;
        m = k % 32;
        if (m < 20) return (((m / 4) % 2) == 0) ? 3'b101 : 3'b011;
        return 3'b001;
    endfunction

    // Expected output for cycle j of a sounding chirp.
    function automatic logic [2:0] tone_exp(input int j);
        return (((j / 4) % 2) == 0) ? 3'b101 : 3'b011;
    endfunction

    task automatic chk(input string tag, input logic [2:0] exp);
        logic [2:0] obs;
        obs = {buzz, buzz_n, busy};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s {buzz,buzz_n,busy} observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] exp);
        @(negedge clk);
        chk(tag, exp);
    endtask

    initial begin
        rst = 1'b1;
        in_transit = 1'b0;
        OK2Move = 1'b1;
        arrive = 1'b0;
        #1;
        chk("reset_state", SILENT);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 100; i++) step("idle_hold", SILENT);

        // Alarm cadence held for 100 cycles.
        in_transit = 1'b1;
        OK2Move = 1'b0;
        for (int k = 0; k < 100; k++) step($sformatf("cadence_k%0d", k), cad_exp(k));
        in_transit = 1'b0;
        step("alarm_clear", SILENT);

        // Alarm dropped mid-ALM_ON, then reasserted.
        in_transit = 1'b1;
        for (int k = 0; k < 6; k++) step("drop_pre", cad_exp(k));
        OK2Move = 1'b1;
        step("drop_idle", SILENT);
        OK2Move = 1'b0;
        for (int k = 0; k < 8; k++) step("reassert", cad_exp(k));
        in_transit = 1'b0;
        step("reassert_clear", SILENT);
        step("reassert_clear2", SILENT);

        // Single arrival pulse.
        arrive = 1'b1;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            arrive = 1'b0;
`ifdef BUZZ_CHIRP_EN
            chk($sformatf("chirp_j%0d", j), (j < 10) ? tone_exp(j) : SILENT);
`else
            chk($sformatf("arrive_ignored_j%0d", j), SILENT);
`endif
        end

        // Second arrival after chirp cycle 5 extends sounding to 15 cycles.
        arrive = 1'b1;
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
`ifdef BUZZ_CHIRP_EN
            chk($sformatf("chirp_ext_j%0d", j), (j < 15) ? tone_exp(j) : SILENT);
`else
            chk($sformatf("arrive2_ignored_j%0d", j), SILENT);
`endif
            arrive = (j == 4);
        end

        // Arrival and alarm on the same edge: alarm wins, no chirp afterwards.
        arrive = 1'b1;
        in_transit = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step("both_alarm", cad_exp(k));
            arrive = 1'b0;
        end
        in_transit = 1'b0;
        for (int i = 0; i < 12; i++) step("both_no_chirp", SILENT);

        // Alarm during a chirp aborts it; cadence counts from zero.
        arrive = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            arrive = 1'b0;
`ifdef BUZZ_CHIRP_EN
            chk("abort_chirp", tone_exp(j));
`else
            chk("abort_chirp_absent", SILENT);
`endif
        end
        in_transit = 1'b1;
        for (int k = 0; k < 25; k++) step($sformatf("abort_cad_k%0d", k), cad_exp(k));
        in_transit = 1'b0;
        step("abort_clear", SILENT);

        // Asynchronous reset mid-tone.
        in_transit = 1'b1;
        step("pre_reset_tone", cad_exp(0));
        step("pre_reset_tone2", cad_exp(1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", SILENT);
        in_transit = 1'b0;
        @(negedge clk);
        chk("reset_held", SILENT);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step("post_reset_idle", SILENT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
